// File: rtl/branch_predict_unit_if.sv
// Fetch/decode-side signals of the branch predict unit: lookup PC, the branch in ID,
// and the redirect and statistics returned to the pipeline.
interface branch_predict_unit_if #(
   parameter int PC_W  = 16,
   parameter int CNT_W = 16
);
   logic             stall;
   logic [PC_W-1:0]  if_pc;
   logic [PC_W-1:0]  pred_pc;
   logic             id_valid;
   logic [1:0]       id_branch;
   logic [2:0]       id_cond;
   logic [2:0]       id_flags;
   logic [8:0]       id_imm;
   logic [PC_W-1:0]  id_rs;
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;
   logic             flush;
   logic             branch_taken;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   modport master (
      output stall, if_pc, id_valid, id_branch, id_cond, id_flags, id_imm, id_rs,
      input  pred_pc, redirect, redirect_pc, flush, branch_taken, branch_cnt, mispred_cnt
   );

   modport slave (
      input  stall, if_pc, id_valid, id_branch, id_cond, id_flags, id_imm, id_rs,
      output pred_pc, redirect, redirect_pc, flush, branch_taken, branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: predicts the next fetch PC in IF,
// resolves B/BR in ID and redirects fetch only when the prediction was wrong.
module branch_predict_unit #(
   parameter int         PC_W     = 16,
   parameter int         DEPTH    = 16,
   parameter int         CNT_W    = 16,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic                 clk,
   input  logic                 rst_n,
   branch_predict_unit_if.slave bp
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = PC_W - IDX_W - 1;

   logic [DEPTH-1:0] btb_valid;
   logic [TAG_W-1:0] btb_tag    [DEPTH];
   logic [1:0]       btb_ctr    [DEPTH];
   logic [PC_W-1:0]  btb_target [DEPTH];

   logic [PC_W-1:0]  pc2_id;
   logic [PC_W-1:0]  pred_pc_id;

   // Fetch lookup
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic             pred_taken;
   logic [PC_W-1:0]  pc2_if;
   logic [PC_W-1:0]  pred_next;

   assign pc2_if     = bp.if_pc + PC_W'(2);
   assign f_idx      = bp.if_pc[IDX_W:1];
   assign f_tag      = bp.if_pc[PC_W-1:IDX_W+1];
   assign f_hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign pred_taken = f_hit & btb_ctr[f_idx][1];
   assign pred_next  = pred_taken ? btb_target[f_idx] : pc2_if;
   assign bp.pred_pc = pred_next;

   // Resolution in ID
   logic             flag_v, flag_n, flag_z;
   logic             cond_ok;
   logic             actual;
   logic [PC_W-1:0]  imm_off;
   logic [PC_W-1:0]  br_target;
   logic [PC_W-1:0]  actual_next;
   logic             upd;
   logic             mispred;

   assign {flag_v, flag_n, flag_z} = bp.id_flags;

   always_comb begin
      cond_ok = 1'b0;
      case (bp.id_cond)
         3'b000:  cond_ok = ~flag_z;
         3'b001:  cond_ok = flag_z;
         3'b010:  cond_ok = ~flag_z & ~flag_n;
         3'b011:  cond_ok = flag_n;
         3'b100:  cond_ok = flag_z | (~flag_z & ~flag_n);
         3'b101:  cond_ok = flag_z | flag_n;
         3'b110:  cond_ok = flag_v;
         default: cond_ok = 1'b1;
      endcase
   end

   assign imm_off     = {{(PC_W-10){bp.id_imm[8]}}, bp.id_imm, 1'b0};
   assign br_target   = bp.id_branch[0] ? (pc2_id + imm_off) : bp.id_rs;
   assign actual      = bp.id_branch[1] & cond_ok;
   assign actual_next = actual ? br_target : pc2_id;
   assign upd         = bp.id_valid & ~bp.stall;
   assign mispred     = upd & (pred_pc_id != actual_next);

   assign bp.redirect     = mispred;
   assign bp.flush        = mispred;
   assign bp.redirect_pc  = actual_next;
   assign bp.branch_taken = actual & bp.id_valid;

   // Table update uses the PC of the instruction in ID
   logic [PC_W-1:0]  pc_id;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;

   assign pc_id = pc2_id - PC_W'(2);
   assign u_idx = pc_id[IDX_W:1];
   assign u_tag = pc_id[PC_W-1:IDX_W+1];
   assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

   // PCs are halfword aligned, so bit 0 never takes part in index or tag
   logic unused_bits;
   assign unused_bits = bp.if_pc[0] ^ pc_id[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            btb_tag[i]    <= '0;
            btb_ctr[i]    <= INIT_CTR;
            btb_target[i] <= '0;
         end
      end else if (upd) begin
         if (bp.id_branch[1]) begin
            if (u_hit) begin
               if (actual) begin
                  if (btb_ctr[u_idx] != 2'b11) btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'd1;
                  btb_target[u_idx] <= br_target;
               end else if (btb_ctr[u_idx] != 2'b00) begin
                  btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'd1;
               end
            end else begin
               btb_valid[u_idx]  <= 1'b1;
               btb_tag[u_idx]    <= u_tag;
               btb_ctr[u_idx]    <= actual ? 2'b10 : INIT_CTR;
               btb_target[u_idx] <= br_target;
            end
         end else if (u_hit) begin
            btb_valid[u_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc2_id         <= '0;
         pred_pc_id     <= '0;
         bp.branch_cnt  <= '0;
         bp.mispred_cnt <= '0;
      end else if (!bp.stall) begin
         pc2_id     <= pc2_if;
         pred_pc_id <= pred_next;
         if (bp.id_valid && bp.id_branch[1] && (bp.branch_cnt != '1))
            bp.branch_cnt <= bp.branch_cnt + CNT_W'(1);
         if (mispred && (bp.mispred_cnt != '1))
            bp.mispred_cnt <= bp.mispred_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: expectations queued at stimulus time
// and popped when the corresponding DUT output is sampled.
module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic rst_n;

   branch_predict_unit_if #(.PC_W(16), .CNT_W(16)) bp ();

   branch_predict_unit #(.PC_W(16), .DEPTH(16), .CNT_W(16), .INIT_CTR(2'b01)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bp)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic chk(input string t, input logic [31:0] exp_v, input logic [31:0] obs);
      push(t, exp_v);
      pop_check(obs);
   endtask

   task automatic drive(input logic [15:0] pc, input logic v, input logic [1:0] br,
                        input logic [2:0] c, input logic [2:0] f, input logic [8:0] imm,
                        input logic [15:0] rs, input logic st);
      @(negedge clk);
      bp.if_pc     = pc;
      bp.id_valid  = v;
      bp.id_branch = br;
      bp.id_cond   = c;
      bp.id_flags  = f;
      bp.id_imm    = imm;
      bp.id_rs     = rs;
      bp.stall     = st;
      #2;
   endtask

   task automatic fetch_check(input logic [15:0] pc, input logic [15:0] exp_pred);
      drive(pc, 1'b0, 2'b00, 3'd0, 3'd0, 9'd0, 16'h0, 1'b0);
      chk("pred_pc", 32'(exp_pred), 32'(bp.pred_pc));
   endtask

   task automatic cnt_check(input logic [15:0] exp_b, input logic [15:0] exp_m);
      drive(16'h0, 1'b0, 2'b00, 3'd0, 3'd0, 9'd0, 16'h0, 1'b0);
      chk("branch_cnt", 32'(exp_b), 32'(bp.branch_cnt));
      chk("mispred_cnt", 32'(exp_m), 32'(bp.mispred_cnt));
   endtask

   // Fetch pc in one cycle, resolve it in ID in the next.
   task automatic branch_step(input logic [15:0] pc, input logic [1:0] br, input logic [2:0] c,
                              input logic [2:0] f, input logic [8:0] imm, input logic [15:0] rs,
                              input logic [15:0] exp_pred, input logic exp_redir,
                              input logic [15:0] exp_rpc, input logic exp_taken);
      drive(pc, 1'b0, 2'b00, 3'd0, 3'd0, 9'd0, 16'h0, 1'b0);
      push("pred_pc", 32'(exp_pred));
      push("redirect", 32'(exp_redir));
      push("flush", 32'(exp_redir));
      push("redirect_pc", 32'(exp_rpc));
      push("branch_taken", 32'(exp_taken));
      pop_check(32'(bp.pred_pc));
      drive(pc + 16'd2, 1'b1, br, c, f, imm, rs, 1'b0);
      pop_check(32'(bp.redirect));
      pop_check(32'(bp.flush));
      pop_check(32'(bp.redirect_pc));
      pop_check(32'(bp.branch_taken));
   endtask

   function automatic logic cond_model(input logic [2:0] c, input logic [2:0] f);
      logic v, n, z;
      {v, n, z} = f;
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return z || n;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bp.if_pc     = 16'h0010;
      bp.id_valid  = 1'b0;
      bp.id_branch = 2'b00;
      bp.id_cond   = 3'd0;
      bp.id_flags  = 3'd0;
      bp.id_imm    = 9'd0;
      bp.id_rs     = 16'h0;
      bp.stall     = 1'b0;
      #3;
      chk("reset pred_pc", 32'h0012, 32'(bp.pred_pc));
      chk("reset redirect", 32'h0, 32'(bp.redirect));
      chk("reset branch_cnt", 32'h0, 32'(bp.branch_cnt));
      chk("reset btb_valid", 32'h0, 32'(dut.btb_valid));
      @(negedge clk);
      rst_n = 1'b1;

      // Unconditional B, cold, then retrained refetch
      branch_step(16'h0010, 2'b11, 3'b111, 3'd0, 9'd4, 16'h0, 16'h0012, 1'b1, 16'h001A, 1'b1);
      cnt_check(16'd1, 16'd1);
      chk("ctr after cold B", 32'h2, 32'(dut.btb_ctr[8]));
      branch_step(16'h0010, 2'b11, 3'b111, 3'd0, 9'd4, 16'h0, 16'h001A, 1'b0, 16'h001A, 1'b1);
      cnt_check(16'd2, 16'd1);

      // BEQ trained taken, then falls through
      branch_step(16'h0020, 2'b11, 3'b001, 3'b001, 9'd8, 16'h0, 16'h0022, 1'b1, 16'h0032, 1'b1);
      branch_step(16'h0020, 2'b11, 3'b001, 3'b001, 9'd8, 16'h0, 16'h0032, 1'b0, 16'h0032, 1'b1);
      cnt_check(16'd4, 16'd2);
      chk("ctr beq saturated", 32'h3, 32'(dut.btb_ctr[0]));
      branch_step(16'h0020, 2'b11, 3'b001, 3'b000, 9'd8, 16'h0, 16'h0032, 1'b1, 16'h0022, 1'b0);
      cnt_check(16'd5, 16'd3);
      chk("ctr beq after not-taken", 32'h2, 32'(dut.btb_ctr[0]));
      fetch_check(16'h0020, 16'h0032);

      // BR target change
      branch_step(16'h0040, 2'b10, 3'b111, 3'd0, 9'd0, 16'h0100, 16'h0042, 1'b1, 16'h0100, 1'b1);
      branch_step(16'h0040, 2'b10, 3'b111, 3'd0, 9'd0, 16'h0200, 16'h0100, 1'b1, 16'h0200, 1'b1);
      fetch_check(16'h0040, 16'h0200);
      cnt_check(16'd7, 16'd5);

      // Tag alias: non-branch at 0x0030 leaves 0x0010's entry alone
      branch_step(16'h0030, 2'b00, 3'b111, 3'd0, 9'd0, 16'h0, 16'h0032, 1'b0, 16'h0032, 1'b0);
      fetch_check(16'h0010, 16'h001A);
      chk("ctr after alias", 32'h3, 32'(dut.btb_ctr[8]));
      cnt_check(16'd7, 16'd5);

      // Mispredicting branch held by stall, released once
      fetch_check(16'h0070, 16'h0072);
      for (int i = 0; i < 3; i++) begin
         drive(16'h0100, 1'b1, 2'b11, 3'b111, 3'd0, 9'd2, 16'h0, 1'b1);
         chk("stalled redirect", 32'h0, 32'(bp.redirect));
      end
      chk("stalled branch_cnt", 32'd7, 32'(bp.branch_cnt));
      chk("stalled mispred_cnt", 32'd5, 32'(bp.mispred_cnt));
      drive(16'h0072, 1'b1, 2'b11, 3'b111, 3'd0, 9'd2, 16'h0, 1'b0);
      chk("unstalled redirect", 32'h1, 32'(bp.redirect));
      chk("unstalled redirect_pc", 32'h0076, 32'(bp.redirect_pc));
      cnt_check(16'd8, 16'd6);

      // PC wrap
      branch_step(16'hFFFE, 2'b11, 3'b111, 3'd0, 9'd1, 16'h0, 16'h0000, 1'b1, 16'h0002, 1'b1);
      cnt_check(16'd9, 16'd7);

      // Non-branch hitting a trained entry invalidates it
      branch_step(16'h0040, 2'b00, 3'b111, 3'd0, 9'd0, 16'h0, 16'h0200, 1'b1, 16'h0042, 1'b0);
      fetch_check(16'h0040, 16'h0042);
      cnt_check(16'd9, 16'd8);

      // Condition codes, evaluated under stall so nothing updates
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            drive(16'h0000, 1'b1, 2'b11, 3'(c), 3'(f), 9'd0, 16'h0, 1'b1);
            push("cond taken", 32'(cond_model(3'(c), 3'(f))));
            pop_check(32'(bp.branch_taken));
         end
      end
      cnt_check(16'd9, 16'd8);

      // Mid-run async reset
      fetch_check(16'h0070, 16'h0076);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset pred_pc trained", 32'h0072, 32'(bp.pred_pc));
      chk("midreset branch_cnt", 32'h0, 32'(bp.branch_cnt));
      chk("midreset mispred_cnt", 32'h0, 32'(bp.mispred_cnt));
      chk("midreset btb_valid", 32'h0, 32'(dut.btb_valid));
      chk("midreset ctr", 32'h1, 32'(dut.btb_ctr[8]));
      chk("midreset redirect", 32'h0, 32'(bp.redirect));
      chk("midreset branch_taken", 32'h0, 32'(bp.branch_taken));
      bp.if_pc = 16'h0010;
      #1;
      chk("midreset pred_pc", 32'h0012, 32'(bp.pred_pc));
      @(negedge clk);
      rst_n = 1'b1;
      fetch_check(16'h0010, 16'h0012);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle PC/branch resolution logic. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating-counter direction prediction, which supplies a predicted next PC to fetch every cycle. It resolves B/BR instructions in ID, redirects fetch and flushes IF/ID only on a misprediction, and keeps saturating performance counters. It sits between the PC register (IF) and the IF/ID pipeline boundary.

## Interface
- PC_W, 16, PC and target width.
- DEPTH, 16, BTB entries; power of 2, ≥2. IDX_W = log2(DEPTH).
- CNT_W, 16, performance counter width.
- INIT_CTR, 2'b01, counter value used on reset and for a not-taken allocation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freezes the IF/ID prediction register and blocks all resolution, table and counter updates.
- if_pc  in  PC_W  current fetch PC.
- pred_pc  out  PC_W  predicted next fetch PC; combinational.
- id_valid  in  1  ID holds a real (non-flushed) instruction.
- id_branch  in  2  [1] = branch instruction; [0] = 1 for B (PC-relative), 0 for BR (register).
- id_cond  in  3  condition code: 000 NE, 001 EQ, 010 GT, 011 LT, 100 GE, 101 LE, 110 OVF, 111 unconditional.
- id_flags  in  3  [2] = V, [1] = N, [0] = Z.
- id_imm  in  9  signed word offset for B.
- id_rs  in  PC_W  register target for BR.
- redirect  out  1  misprediction; fetch must load redirect_pc.
- redirect_pc  out  PC_W  corrected next PC.
- flush  out  1  equal to redirect; squashes IF/ID.
- branch_taken  out  1  resolved outcome of the branch in ID.
- branch_cnt  out  CNT_W  resolved branches; saturating.
- mispred_cnt  out  CNT_W  mispredictions; saturating.

## Operation
- **Entry format:** valid, tag = pc[PC_W-1:IDX_W+1], ctr[1:0], target[PC_W-1:0].
- **Indexing:** index = pc[IDX_W:1].
- **Fetch lookup (combinational):**
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_pc = pred_taken ? target : if_pc+2.
- **IF/ID register:** when ~stall, captures {if_pc+2, pred_taken, pred_pc} every cycle. It has no separate valid bit; id_valid qualifies it.
- **Condition evaluation:**
  - NE: ~Z
  - EQ: Z
  - GT: ~Z & ~N
  - LT: N
  - GE: Z | (~Z & ~N)
  - LE: Z | N
  - OVF: V
  - unconditional: 1
- **Resolution (combinational):**
  - actual = id_branch[1] & cond.
  - target = id_branch[0] ? pc2_id + (sext(id_imm) << 1) : id_rs. The sum wraps mod 2^PC_W.
  - actual_next = actual ? target : pc2_id.
- **Misprediction:** mispred = id_valid & ~stall & (pred_pc_id != actual_next).
  - redirect = flush = mispred.
  - redirect_pc = actual_next.
  - branch_taken = actual & id_valid.
- **Table update** (only when id_valid & ~stall). The entry index and tag come from pc_id = pc2_id − 2.
  - Branch, tag hit: ctr increments (taken) or decrements (not taken), saturating at 11 and 00. target is written only when taken.
  - Branch, miss: allocate with valid = 1, the new tag, ctr = actual ? 2'b10 : INIT_CTR, and target.
  - Non-branch that hit: clear valid.
- **Counters:**
  - branch_cnt increments on id_valid & ~stall & id_branch[1].
  - mispred_cnt increments on mispred.
  - Both hold at all-ones.

## Timing
- **Reset (async):**
  - All valid bits = 0; all ctr = INIT_CTR.
  - IF/ID register = 0; both counters = 0.
  - redirect = flush = branch_taken = 0; pred_pc = if_pc+2.
  - Applies immediately, including mid-operation.
- **Latency:**
  - Prediction: 0 cycles.
  - Resolution: 1 cycle after fetch; redirect is asserted in the cycle the branch is in ID.
  - Table write becomes visible to lookups on the next edge.
- **Same-cycle read and write to one index:** the fetch lookup sees the old entry; no bypass.
- **Stall:** while stall = 1, redirect is 0 and nothing updates. A pending misprediction asserts in the first cycle stall is low, and is counted once.
- **Wrong-path fetch:** the instruction fetched in the redirect cycle is captured normally. The pipeline drives id_valid = 0 for it, so it has no effect.

## Test plan
- **Reset:** pulse rst_n low mid-run with if_pc = 0x0010 → pred_pc = 0x0012; redirect, branch_taken = 0; both counters = 0; all entries invalid.
- **Unconditional B, cold:** B at 0x0010, C = 111, imm = +4, cold → in ID: redirect = 1, redirect_pc = 0x001A, mispred_cnt = 1, entry ctr = 10. Refetch of 0x0010 → pred_pc = 0x001A; resolves with redirect = 0, branch_cnt = 2.
- **Trained BEQ, falls through:** BEQ at 0x0020 taken twice (ctr = 11), then Z = 0 → redirect = 1, redirect_pc = 0x0022, ctr = 10. Next fetch of 0x0020 still predicts taken.
- **BR target change:** BR (id_branch = 10, C = 111) at 0x0040; rs = 0x0100, then rs = 0x0200 → second resolve: redirect = 1, redirect_pc = 0x0200. Next prediction = 0x0200.
- **Tag alias:** 0x0010 trained, fetch 0x0030 (same index, different tag) → pred_pc = 0x0032. Non-branch at 0x0030 in ID → no update, no redirect.
- **Stall and wrap:**
  - Mispredicting branch held 3 cycles with stall = 1 → redirect = 0 throughout; asserts on the first unstalled cycle; mispred_cnt increments by exactly 1.
  - B at 0xFFFE, imm = +1 → redirect_pc = 0x0002.
